// File: rtl/msdap_pkg.sv
// Shared types and helper constants for the MSDAP sparse-convolution engine.
// Saturation limits are used only when MSDAP_SATURATE_EN is defined.
package msdap_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRjReq,
        StRjWait,
        StTerm,
        StDrain,
        StShift,
        StFin
    } lane_state_e;

    // Sign lives just above the delay field of a coefficient word.
    function automatic int unsigned coeff_sign_bit(input int unsigned daddr_w);
        return daddr_w;
    endfunction

    // Signed limits for a w-bit accumulator (w <= 64), returned zero-extended.
    function automatic logic [63:0] sat_max(input int unsigned w);
        return 64'h7FFF_FFFF_FFFF_FFFF >> (64 - w);
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/msdap_conv_engine_if.sv
// Control handshake between the frame controller and the convolution engine.
interface msdap_conv_engine_if #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned DADDR_W = 8,
    parameter int unsigned ACC_W   = 40
);
    logic                    start;
    logic                    abort;
    logic [DADDR_W-1:0]      newest_addr;
    logic                    busy;
    logic                    done;
    logic [NUM_CH*ACC_W-1:0] result;

    modport master (output start, abort, newest_addr, input busy, done, result);
    modport slave  (input start, abort, newest_addr, output busy, done, result);
endinterface

// File: rtl/msdap_conv_lane.sv
// One convolution lane: Rj walk, coefficient/data pipeline and accumulator.
// MSDAP_SATURATE_EN selects saturating accumulation instead of two's-complement wrap.
module msdap_conv_lane
    import msdap_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ACC_W       = 40,
    parameter int unsigned RJ_NUM      = 16,
    parameter int unsigned COEFF_DEPTH = 512,
    parameter int unsigned DATA_DEPTH  = 256,
    localparam int unsigned RJ_AW      = $clog2(RJ_NUM),
    localparam int unsigned CADDR_W    = $clog2(COEFF_DEPTH),
    localparam int unsigned DADDR_W    = $clog2(DATA_DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               clear_i,
    input  logic [DADDR_W-1:0] newest_addr_i,
    input  logic [DATA_W-1:0]  rj_data_i,
    input  logic [DATA_W-1:0]  coeff_data_i,
    input  logic [DATA_W-1:0]  data_in_i,
    output logic [RJ_AW-1:0]   rj_addr_o,
    output logic [CADDR_W-1:0] coeff_addr_o,
    output logic [DADDR_W-1:0] data_addr_o,
    output logic               fin_o,
    output logic [ACC_W-1:0]   acc_o
);
    localparam int unsigned SignBit = coeff_sign_bit(DADDR_W);

    lane_state_e        state_q, state_d;
    logic [RJ_AW-1:0]   j_q, j_d;
    logic [DATA_W-1:0]  cnt_q, cnt_d;
    logic [CADDR_W-1:0] cptr_q, cptr_d;
    logic [DADDR_W-1:0] newest_q, newest_d;
    logic               drain_q, drain_d;
    logic               v1_q, v1_d, v2_q, v2_d, sign_q, sign_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   term, sum;
    logic [ACC_W:0]     sum_ext;
    logic               launch, issue, last_j;
    logic               unused_coeff;

    assign unused_coeff = ^coeff_data_i[DATA_W-1:SignBit+1];
    assign launch       = (state_q == StIdle) && start_i && !abort_i;
    assign last_j       = (j_q == RJ_AW'(RJ_NUM - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (start_i) state_d = StRjReq;
                StRjReq:  state_d = StRjWait;
                StRjWait: state_d = (rj_data_i == '0) ? StShift : StTerm;
                StTerm:   if (cnt_q == DATA_W'(1)) state_d = StDrain;
                StDrain:  if (drain_q) state_d = StShift;
                StShift:  state_d = last_j ? StFin : StRjReq;
                StFin:    if (clear_i) state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        issue        = (state_q == StTerm);
        fin_o        = (state_q == StFin);
        rj_addr_o    = j_q;
        coeff_addr_o = cptr_q;
        // Delay field arrives one cycle after the coefficient address; address wraps naturally.
        data_addr_o  = v1_q ? (newest_q - coeff_data_i[DADDR_W-1:0]) : '0;
        acc_o        = acc_q;
    end

    always_comb begin
        j_d      = j_q;
        cnt_d    = cnt_q;
        cptr_d   = cptr_q;
        newest_d = newest_q;
        drain_d  = (state_q == StDrain) && !drain_q && !abort_i;
        v1_d     = issue && !abort_i;
        v2_d     = v1_q && !abort_i;
        sign_d   = coeff_data_i[SignBit];
        if (launch) begin
            j_d      = '0;
            cptr_d   = '0;
            newest_d = newest_addr_i;
        end
        if (state_q == StRjWait) cnt_d = rj_data_i;
        if (issue) begin
            cnt_d  = cnt_q - DATA_W'(1);
            cptr_d = cptr_q + CADDR_W'(1);
        end
        if (state_q == StShift) j_d = j_q + RJ_AW'(1);
    end

    always_comb begin
        term    = {{(ACC_W - 2 * DATA_W){data_in_i[DATA_W-1]}}, data_in_i, {DATA_W{1'b0}}};
        sum_ext = sign_q ? ({acc_q[ACC_W-1], acc_q} - {term[ACC_W-1], term})
                         : ({acc_q[ACC_W-1], acc_q} + {term[ACC_W-1], term});
`ifdef MSDAP_SATURATE_EN
        if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
            sum = sum_ext[ACC_W] ? ACC_W'(sat_min(ACC_W)) : ACC_W'(sat_max(ACC_W));
        end else begin
            sum = sum_ext[ACC_W-1:0];
        end
`else
        sum = sum_ext[ACC_W-1:0];
`endif
        acc_d = acc_q;
        if (abort_i || launch) begin
            acc_d = '0;
        end else if (v2_q) begin
            acc_d = sum;
        end else if (state_q == StShift) begin
            acc_d = {acc_q[ACC_W-1], acc_q[ACC_W-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            j_q      <= '0;
            cnt_q    <= '0;
            cptr_q   <= '0;
            newest_q <= '0;
            drain_q  <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            sign_q   <= 1'b0;
            acc_q    <= '0;
        end else begin
            j_q      <= j_d;
            cnt_q    <= cnt_d;
            cptr_q   <= cptr_d;
            newest_q <= newest_d;
            drain_q  <= drain_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            sign_q   <= sign_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/msdap_conv_engine.sv
// Multi-lane sparse-convolution engine: start/abort/done aggregation over NUM_CH lanes.
// Accumulation mode per lane is selected by MSDAP_SATURATE_EN.
module msdap_conv_engine
    import msdap_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ACC_W       = 40,
    parameter int unsigned RJ_NUM      = 16,
    parameter int unsigned COEFF_DEPTH = 512,
    parameter int unsigned DATA_DEPTH  = 256,
    localparam int unsigned RJ_AW      = $clog2(RJ_NUM),
    localparam int unsigned CADDR_W    = $clog2(COEFF_DEPTH),
    localparam int unsigned DADDR_W    = $clog2(DATA_DEPTH)
) (
    input  logic                      SCLK,
    input  logic                      Reset_n,
    msdap_conv_engine_if.slave        ctrl,
    output logic [NUM_CH*RJ_AW-1:0]   rj_addr,
    input  logic [NUM_CH*DATA_W-1:0]  rj_data,
    output logic [NUM_CH*CADDR_W-1:0] coeff_addr,
    input  logic [NUM_CH*DATA_W-1:0]  coeff_data,
    output logic [NUM_CH*DADDR_W-1:0] data_addr,
    input  logic [NUM_CH*DATA_W-1:0]  data_in
);
    logic                    busy_q, busy_d, done_q, done_d;
    logic [NUM_CH*ACC_W-1:0] result_q, result_d;
    logic [NUM_CH*ACC_W-1:0] lane_acc;
    logic [NUM_CH-1:0]       lane_fin;
    logic                    start_acc, finish;

    always_comb begin
        start_acc = ctrl.start && !busy_q && !ctrl.abort;
        // Lanes are released back to idle on the same edge that raises done.
        finish    = busy_q && (&lane_fin) && !ctrl.abort;
        busy_d    = busy_q;
        if (ctrl.abort) begin
            busy_d = 1'b0;
        end else if (start_acc) begin
            busy_d = 1'b1;
        end else if (finish) begin
            busy_d = 1'b0;
        end
        done_d   = finish;
        result_d = finish ? lane_acc : result_q;
    end

    always_ff @(posedge SCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign ctrl.busy   = busy_q;
    assign ctrl.done   = done_q;
    assign ctrl.result = result_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        msdap_conv_lane #(
            .DATA_W      (DATA_W),
            .ACC_W       (ACC_W),
            .RJ_NUM      (RJ_NUM),
            .COEFF_DEPTH (COEFF_DEPTH),
            .DATA_DEPTH  (DATA_DEPTH)
        ) u_lane (
            .clk_i         (SCLK),
            .rst_ni        (Reset_n),
            .start_i       (start_acc),
            .abort_i       (ctrl.abort),
            .clear_i       (finish),
            .newest_addr_i (ctrl.newest_addr),
            .rj_data_i     (rj_data[g*DATA_W +: DATA_W]),
            .coeff_data_i  (coeff_data[g*DATA_W +: DATA_W]),
            .data_in_i     (data_in[g*DATA_W +: DATA_W]),
            .rj_addr_o     (rj_addr[g*RJ_AW +: RJ_AW]),
            .coeff_addr_o  (coeff_addr[g*CADDR_W +: CADDR_W]),
            .data_addr_o   (data_addr[g*DADDR_W +: DADDR_W]),
            .fin_o         (lane_fin[g]),
            .acc_o         (lane_acc[g*ACC_W +: ACC_W])
        );
    end

endmodule

// File: tb/tb_msdap_conv_engine.sv
// Scoreboard bench for msdap_conv_engine: directed frames, expected results queued at start.
// Define MSDAP_SATURATE_EN to also run the saturation frame.
module tb_msdap_conv_engine;
    localparam int unsigned NUM_CH = 2, DATA_W = 16, ACC_W = 40, RJ_NUM = 16;
    localparam int unsigned COEFF_DEPTH = 512, DATA_DEPTH = 256;
    localparam int unsigned RJ_AW = 4, CADDR_W = 9, DADDR_W = 8;

    typedef struct {
        logic [ACC_W-1:0] r0;
        logic [ACC_W-1:0] r1;
        int unsigned      lat;
        int unsigned      acc_cyc;
    } exp_t;

    logic SCLK = 1'b0;
    logic Reset_n = 1'b0;
    always #5 SCLK = ~SCLK;

    msdap_conv_engine_if #(.NUM_CH(NUM_CH), .DADDR_W(DADDR_W), .ACC_W(ACC_W)) ctrl ();

    logic [NUM_CH*RJ_AW-1:0]   rj_addr;
    logic [NUM_CH*DATA_W-1:0]  rj_data;
    logic [NUM_CH*CADDR_W-1:0] coeff_addr;
    logic [NUM_CH*DATA_W-1:0]  coeff_data;
    logic [NUM_CH*DADDR_W-1:0] data_addr;
    logic [NUM_CH*DATA_W-1:0]  data_in;

    msdap_conv_engine #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .ACC_W       (ACC_W),
        .RJ_NUM      (RJ_NUM),
        .COEFF_DEPTH (COEFF_DEPTH),
        .DATA_DEPTH  (DATA_DEPTH)
    ) dut (
        .SCLK       (SCLK),
        .Reset_n    (Reset_n),
        .ctrl       (ctrl),
        .rj_addr    (rj_addr),
        .rj_data    (rj_data),
        .coeff_addr (coeff_addr),
        .coeff_data (coeff_data),
        .data_addr  (data_addr),
        .data_in    (data_in)
    );

    logic [DATA_W-1:0] rj_m    [NUM_CH][RJ_NUM];
    logic [DATA_W-1:0] coeff_m [NUM_CH][COEFF_DEPTH];
    logic [DATA_W-1:0] x_m     [NUM_CH][DATA_DEPTH];

    // Synchronous memories, one cycle of read latency.
    always @(posedge SCLK) begin
        for (int i = 0; i < NUM_CH; i++) begin
            rj_data[i*DATA_W +: DATA_W]    <= rj_m[i][rj_addr[i*RJ_AW +: RJ_AW]];
            coeff_data[i*DATA_W +: DATA_W] <= coeff_m[i][coeff_addr[i*CADDR_W +: CADDR_W]];
            data_in[i*DATA_W +: DATA_W]    <= x_m[i][data_addr[i*DADDR_W +: DADDR_W]];
        end
    end

    int cyc = 0;
    int n253 = 0;
    always @(posedge SCLK) cyc <= cyc + 1;
    always @(posedge SCLK) if (data_addr[DADDR_W-1:0] == 8'd253) n253 <= n253 + 1;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < NUM_CH; i++) begin
            for (int j = 0; j < RJ_NUM; j++) rj_m[i][j] = '0;
            for (int j = 0; j < COEFF_DEPTH; j++) coeff_m[i][j] = '0;
            for (int j = 0; j < DATA_DEPTH; j++) x_m[i][j] = '0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, 64'(ctrl.busy), 64'd0);
        chk({tag, "_done"}, 64'(ctrl.done), 64'd0);
        chk({tag, "_result"}, 64'(ctrl.result[ACC_W-1:0] | ctrl.result[2*ACC_W-1:ACC_W]), 64'd0);
        chk({tag, "_rj_addr"}, 64'(rj_addr), 64'd0);
        chk({tag, "_coeff_addr"}, 64'(coeff_addr), 64'd0);
        chk({tag, "_data_addr"}, 64'(data_addr), 64'd0);
    endtask

    task automatic wait_done(input int unsigned max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < int'(max) && !seen; i++) begin
            @(posedge SCLK);
            #1;
            if (ctrl.done === 1'b1) seen = 1'b1;
        end
        chk("done_seen_in_time", 64'(seen), 64'd1);
    endtask

    task automatic frame(input logic [7:0] newest, input logic [ACC_W-1:0] r0,
                         input logic [ACC_W-1:0] r1, input int unsigned lat,
                         input int unsigned mid_start);
        exp_t e;
        @(negedge SCLK);
        e.r0 = r0;
        e.r1 = r1;
        e.lat = lat;
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        ctrl.newest_addr = newest;
        ctrl.start = 1'b1;
        @(negedge SCLK);
        ctrl.start = 1'b0;
        chk("busy_after_start", 64'(ctrl.busy), 64'd1);
        if (mid_start != 0) begin
            repeat (mid_start) @(negedge SCLK);
            ctrl.newest_addr = newest + 8'd1;
            ctrl.start = 1'b1;
            @(negedge SCLK);
            ctrl.start = 1'b0;
        end
        wait_done(500);
        chk("busy_low_at_done", 64'(ctrl.busy), 64'd0);
    endtask

    task automatic unchecked_start(input logic [7:0] newest);
        @(negedge SCLK);
        ctrl.newest_addr = newest;
        ctrl.start = 1'b1;
        @(negedge SCLK);
        ctrl.start = 1'b0;
    endtask

    // Monitor: every done pops one expected frame.
    initial begin
        exp_t e;
        forever begin
            @(posedge SCLK);
            #1;
            if (ctrl.done === 1'b1) begin
                chk("done_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("result_lane0", 64'(ctrl.result[ACC_W-1:0]), 64'(e.r0));
                    chk("result_lane1", 64'(ctrl.result[2*ACC_W-1:ACC_W]), 64'(e.r1));
                    chk("done_latency", 64'(cyc - int'(e.acc_cyc)), 64'(e.lat));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        ctrl.start = 1'b0;
        ctrl.abort = 1'b0;
        ctrl.newest_addr = '0;
        clr();
        repeat (3) @(negedge SCLK);
        check_reset_values("reset");
        Reset_n = 1'b1;

        // Single tap on the last segment.
        rj_m[0][15] = 16'd1;
        x_m[0][10] = 16'h0001;
        frame(8'd10, 40'h00_0000_8000, 40'h0, 52, 0);

        // Same tap subtracted.
        coeff_m[0][0] = 16'h0100;
        frame(8'd10, 40'hFF_FFFF_8000, 40'h0, 52, 0);

        // Tap in segment 0 goes through all sixteen shifts.
        clr();
        rj_m[0][0] = 16'd1;
        x_m[0][10] = 16'h4000;
        frame(8'd10, 40'h00_0000_4000, 40'h0, 52, 0);

        // Address wrap on lane 0, negative sample on lane 1.
        clr();
        rj_m[0][15] = 16'd1;
        coeff_m[0][0] = 16'd5;
        x_m[0][253] = 16'h0003;
        x_m[0][2] = 16'h0007;
        rj_m[1][15] = 16'd1;
        x_m[1][2] = 16'hFFFF;
        n0 = n253;
        frame(8'd2, 40'h00_0001_8000, 40'hFF_FFFF_8000, 52, 0);
        chk("wrap_addr_253_issued", 64'(n253 - n0), 64'd1);

        // Lane skew with an ignored mid-run start.
        clr();
        rj_m[1][0] = 16'd10;
        for (int t = 0; t < 10; t++) begin
            coeff_m[1][t] = 16'(t) | ((t == 3) ? 16'h0100 : 16'h0000);
            x_m[1][8'(100 - t)] = 16'(t + 1);
        end
        frame(8'd100, 40'h0, 40'h00_0000_002F, 61, 20);
        repeat (70) @(negedge SCLK);

        // Coefficient pointer continues across segments; back-to-back frames.
        clr();
        rj_m[0][14] = 16'd2;
        rj_m[0][15] = 16'd1;
        coeff_m[0][1] = 16'd1;
        coeff_m[0][2] = 16'd2;
        x_m[0][50] = 16'h0010;
        x_m[0][49] = 16'h0020;
        x_m[0][48] = 16'h0040;
        rj_m[1][15] = 16'd1;
        x_m[1][50] = 16'h8000;
        frame(8'd50, 40'h00_002C_0000, 40'hFF_C000_0000, 56, 0);
        frame(8'd50, 40'h00_002C_0000, 40'hFF_C000_0000, 56, 0);

        // Abort mid-run: no done, previous result held.
        unchecked_start(8'd50);
        repeat (10) @(negedge SCLK);
        ctrl.abort = 1'b1;
        @(negedge SCLK);
        ctrl.abort = 1'b0;
        chk("busy_after_abort", 64'(ctrl.busy), 64'd0);
        repeat (80) @(negedge SCLK);
        chk("abort_result_lane0", 64'(ctrl.result[ACC_W-1:0]), 64'h00_002C_0000);
        chk("abort_result_lane1", 64'(ctrl.result[2*ACC_W-1:ACC_W]), 64'hFF_C000_0000);
        frame(8'd50, 40'h00_002C_0000, 40'hFF_C000_0000, 56, 0);

        // Reset asserted mid-run.
        unchecked_start(8'd50);
        repeat (20) @(negedge SCLK);
        Reset_n = 1'b0;
        #1;
        check_reset_values("midrun_reset");
        repeat (2) @(negedge SCLK);
        Reset_n = 1'b1;
        repeat (80) @(negedge SCLK);

        clr();
        rj_m[0][15] = 16'd1;
        x_m[0][10] = 16'h0001;
        frame(8'd10, 40'h00_0000_8000, 40'h0, 52, 0);

`ifdef MSDAP_SATURATE_EN
        clr();
        rj_m[0][15] = 16'd300;
        x_m[0][10] = 16'h7FFF;
        frame(8'd10, 40'h3F_FFFF_FFFF, 40'h0, 351, 0);
`endif

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
